// File: rtl/bru_pkg.sv
// Branch resolve unit shared types: CTI kind encoding and pipeline metadata.
package bru_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } bru_kind_e;

  // Prediction metadata carried alongside an instruction through IF/ID.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bru_meta_t;

  // ID/EX copy additionally carries the decoded CTI kind.
  typedef struct packed {
    bru_meta_t meta;
    bru_kind_e kind;
  } bru_meta_ex_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/bru_meta_stage.sv
// Metadata register slice with hold, bubble and clear. Bubble and clear both
// zero the slice, which drops the valid bit along with the payload.
module bru_meta_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         bubble,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Priority: reset, then clear (flush), then bubble, then hold, else load.
  always_ff @(posedge clk) begin
    if (reset || clear || bubble) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks prediction metadata through IF/ID and ID/EX,
// resolves control transfers in EX, raises flush/redirect on mispredict and
// emits a predictor update packet.
// Optional feature: define BRU_PERF_CNT_EN to add cnt_cti / cnt_mispred.
module branch_resolve_unit
  import bru_pkg::*;
(
`ifdef BRU_PERF_CNT_EN
  output logic [31:0] cnt_cti,
  output logic [31:0] cnt_mispred,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        stall,
  input  logic [1:0]  id_kind,
  input  logic        ex_bcond,
  input  logic [31:0] ex_pc_plus_imm,
  input  logic [31:0] ex_alu_result,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic [1:0]  upd_kind
);

  bru_meta_t    s1_d, s1_q;
  bru_meta_ex_t s2_d, s2_q;

  logic        actual_taken;
  logic [31:0] actual_target;
  logic [31:0] s2_fall_through;
  logic        mispredict;

  assign s1_d = '{valid: fetch_valid, pc: fetch_pc,
                  pred_taken: pred_taken, pred_target: pred_target};
  assign s2_d = '{meta: s1_q, kind: bru_kind_e'(id_kind)};

  bru_meta_stage #(.W($bits(bru_meta_t))) u_s1 (
    .clk    (clk),
    .reset  (reset),
    .hold   (stall),
    .bubble (1'b0),
    .clear  (flush),
    .d      (s1_d),
    .q      (s1_q)
  );

  bru_meta_stage #(.W($bits(bru_meta_ex_t))) u_s2 (
    .clk    (clk),
    .reset  (reset),
    .hold   (1'b0),
    .bubble (stall),
    .clear  (flush),
    .d      (s2_d),
    .q      (s2_q)
  );

  assign s2_fall_through = s2_q.meta.pc + PC_STEP;

  // Resolve the actual direction/target of the ID/EX instruction.
  always_comb begin
    actual_taken  = 1'b0;
    actual_target = s2_fall_through;
    case (s2_q.kind)
      KIND_BRANCH: begin
        actual_taken  = ex_bcond;
        actual_target = ex_pc_plus_imm;
      end
      KIND_JAL: begin
        actual_taken  = 1'b1;
        actual_target = ex_pc_plus_imm;
      end
      KIND_JALR: begin
        actual_taken  = 1'b1;
        actual_target = ex_alu_result & ~32'd1;
      end
      default: begin
        actual_taken  = 1'b0;
        actual_target = s2_fall_through;
      end
    endcase
  end

  // Mispredict detection, redirect selection and predictor update packet.
  // Outputs are gated by reset so nothing fires while the stages are clearing.
  always_comb begin
    mispredict = s2_q.meta.valid && !reset &&
                 ((s2_q.meta.pred_taken != actual_taken) ||
                  (actual_taken && (s2_q.meta.pred_target != actual_target)));
    flush       = mispredict;
    if (!mispredict) redirect_pc = fetch_pc + PC_STEP;
    else if (actual_taken) redirect_pc = actual_target;
    else redirect_pc = s2_fall_through;
    upd_valid  = s2_q.meta.valid && !reset &&
                 ((s2_q.kind != KIND_NONE) || s2_q.meta.pred_taken);
    upd_pc     = s2_q.meta.pc;
    upd_target = actual_target;
    upd_taken  = actual_taken;
    upd_kind   = s2_q.kind;
  end

`ifdef BRU_PERF_CNT_EN
  // Saturating event counters for resolved CTIs and mispredicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_cti     <= '0;
      cnt_mispred <= '0;
    end else begin
      if (upd_valid && (cnt_cti != 32'hFFFF_FFFF)) cnt_cti <= cnt_cti + 32'd1;
      if (flush && (cnt_mispred != 32'hFFFF_FFFF)) cnt_mispred <= cnt_mispred + 32'd1;
    end
  end
`endif

endmodule
